// File: rtl/seq_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package seq_cmp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Result of one chunk compare; EQ means "keep scanning toward the LSB".
    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mag_comp_if.sv
// Start/busy/done handshake plus operands and result flags.
interface seq_mag_comp_if
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2(NCHUNK) + 1;

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic [CW-1:0]    cmp_cycles;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b, cmp_cycles
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, a_gt_b, a_lt_b, a_eq_b, cmp_cycles
    );
endinterface

// File: rtl/seq_mag_comp_chunk_cmp.sv
// Combinational unsigned compare of one chunk; equality is implied by !gt && !lt.
module chunk_cmp #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt
);
    assign gt = (a > b);
    assign lt = (a < b);
endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per cycle from the MSB,
// stopping at the first differing chunk.
module seq_mag_comp
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mag_comp_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2(NCHUNK) + 1;
    localparam int IW     = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cyc_q;
    logic             done_q, gt_q, lt_q, eq_q;

    logic [WIDTH-1:0] msb_flip, a_adj, b_adj;
    logic [CHUNK-1:0] ca, cb;
    logic             c_gt, c_lt;
    logic [1:0]       res;
    logic             last, decide;

    // Signed order equals unsigned order once the sign bits are inverted;
    // the sign bit lives only in the top chunk, so flipping it globally is safe.
    assign msb_flip = sgn_q ? (WIDTH'(1) << (WIDTH - 1)) : '0;
    assign a_adj    = a_q ^ msb_flip;
    assign b_adj    = b_q ^ msb_flip;
    assign ca       = a_adj[idx_q*CHUNK +: CHUNK];
    assign cb       = b_adj[idx_q*CHUNK +: CHUNK];

    chunk_cmp #(.W(CHUNK)) u_chunk_cmp (
        .a  (ca),
        .b  (cb),
        .gt (c_gt),
        .lt (c_lt)
    );

    assign res    = c_gt ? CMP_GT : (c_lt ? CMP_LT : CMP_EQ);
    assign last   = (idx_q == '0);
    assign decide = (res != CMP_EQ) || last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_n;
    end

    // Next-state: accept in IDLE, leave RUN as soon as a decision is made.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_n = ST_RUN;
            ST_RUN:  if (decide)    state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, chunk walk and registered result/done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
            cyc_q  <= '0;
            done_q <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (bus.start) begin
                    a_q   <= bus.a;
                    b_q   <= bus.b;
                    sgn_q <= bus.signed_mode;
                    idx_q <= IW'(NCHUNK - 1);
                    cnt_q <= '0;
                    gt_q  <= 1'b0;
                    lt_q  <= 1'b0;
                    eq_q  <= 1'b0;
                end
            end else if (decide) begin
                gt_q   <= (res == CMP_GT);
                lt_q   <= (res == CMP_LT);
                eq_q   <= (res == CMP_EQ);
                done_q <= 1'b1;
                cyc_q  <= cnt_q + 1'b1;
            end else begin
                idx_q <= idx_q - 1'b1;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = done_q;
    assign bus.a_gt_b     = gt_q;
    assign bus.a_lt_b     = lt_q;
    assign bus.a_eq_b     = eq_q;
    assign bus.cmp_cycles = cyc_q;

endmodule
